latch_checker: RTL

LATCH_CHECKER -- requirements
Module: latch_checker

---
 rtl/latch_chk_pkg.sv | 25 ++
 rtl/lfsr8.sv | 39 +++
 rtl/latch_checker.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/latch_chk_pkg.sv
// -----------------------------------------------------------------------------
// latch_chk_pkg
// Shared definitions for the latch checker: FSM state encoding, LFSR
// polynomial tap mask, the substitute used when a zero seed is loaded, and
// the one-step LFSR transition function.
// -----------------------------------------------------------------------------
package latch_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // x^8 + x^6 + x^5 + x^4 + 1 in right-shifting Galois form.
  localparam logic [7:0] LFSR_TAPS     = 8'hB8;
  // An all-zero LFSR never leaves zero, so a zero seed is replaced.
  localparam logic [7:0] LFSR_ZERO_SUB = 8'h01;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {1'b0, cur[7:1]} ^ (cur[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
// 8-bit Galois LFSR used as the stimulus source of the latch checker.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, q <= 8'h01
//   load - load seed (zero seed replaced by 8'h01); has priority over step
//   seed - value to load
//   step - advance one LFSR step
//   q    - current LFSR state
// -----------------------------------------------------------------------------
module lfsr8
  import latch_chk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] q
);

  logic [7:0] r_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= LFSR_ZERO_SUB;
    end else if (load) begin
      r_q <= (seed == 8'h00) ? LFSR_ZERO_SUB : seed;
    end else if (step) begin
      r_q <= lfsr_next(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/latch_checker.sv
// -----------------------------------------------------------------------------
// latch_checker
// Drives pseudo-random D/EN vectors into an external level-sensitive latch,
// tracks the expected latch value with a reference model, and counts
// matching, mismatching and skipped (model undefined) vectors.
// Each vector takes two cycles: DRIVE registers the stimulus, SAMPLE
// compares the latch output against the model.
// Ports:
//   clk, rst        - clock (rising edge), synchronous active-high reset
//   start           - one-cycle run request (ignored while busy)
//   num_checks      - vectors per run (0 completes immediately with pass)
//   seed            - LFSR seed, sampled when start is accepted
//   d_drv, en_drv   - stimulus to the latch under test
//   dut_out         - latch under test output
//   busy, done      - run in progress / run complete (held)
//   pass            - valid with done, 1 when no mismatch occurred
//   pass_cnt, fail_cnt, skip_cnt - saturating result counters
//   first_fail_idx  - 0-based index of the first mismatching vector
//   err_pulse       - one-cycle pulse per mismatch
// -----------------------------------------------------------------------------
module latch_checker
  import latch_chk_pkg::*;
#(
  parameter int N_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] num_checks,
  input  logic [7:0]     seed,
  output logic           d_drv,
  output logic           en_drv,
  input  logic           dut_out,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [N_W-1:0] pass_cnt,
  output logic [N_W-1:0] fail_cnt,
  output logic [N_W-1:0] skip_cnt,
  output logic [N_W-1:0] first_fail_idx,
  output logic           err_pulse
);

  localparam logic [N_W-1:0] ONE_N = N_W'(1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [7:0]     w_lfsr;
  logic [5:0]     w_lfsr_unused;
  logic           w_start_acc;
  logic           w_last;
  logic           w_exp_nxt;
  logic           w_exp_valid_nxt;
  logic           w_mismatch;

  logic           r_d_drv;
  logic           r_en_drv;
  logic           r_exp;
  logic           r_exp_valid;
  logic           r_err_pulse;
  logic [N_W-1:0] r_idx;
  logic [N_W-1:0] r_num;
  logic [N_W-1:0] r_pass_cnt;
  logic [N_W-1:0] r_fail_cnt;
  logic [N_W-1:0] r_skip_cnt;
  logic [N_W-1:0] r_first_fail;

  function automatic logic [N_W-1:0] sat_inc(input logic [N_W-1:0] v);
    return (v == '1) ? v : v + ONE_N;
  endfunction

  // Start is honoured only when no run is in progress.
  assign w_start_acc = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last      = ((r_idx + ONE_N) == r_num);

  // Reference latch model: transparent while en_drv, otherwise holds.
  assign w_exp_nxt       = r_en_drv ? r_d_drv : r_exp;
  assign w_exp_valid_nxt = r_en_drv | r_exp_valid;
  assign w_mismatch      = w_exp_valid_nxt && (dut_out != w_exp_nxt);

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (w_start_acc),
    .seed (seed),
    .step (r_state == SAMPLE),
    .q    (w_lfsr)
  );

  // Only the two low LFSR bits feed the stimulus.
  assign w_lfsr_unused = w_lfsr[7:2];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and status outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = (num_checks == '0) ? DONE : DRIVE;
      end
      DRIVE: begin
        busy        = 1'b1;
        w_state_nxt = SAMPLE;
      end
      SAMPLE: begin
        busy        = 1'b1;
        w_state_nxt = w_last ? DONE : DRIVE;
      end
      DONE: begin
        done = 1'b1;
        if (start) w_state_nxt = (num_checks == '0) ? DONE : DRIVE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign pass = done && (r_fail_cnt == '0);

  // ---------------------------------------------------------------------------
  // Stimulus, reference model and result counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_drv      <= 1'b0;
      r_en_drv     <= 1'b0;
      r_exp        <= 1'b0;
      r_exp_valid  <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_idx        <= '0;
      r_num        <= '0;
      r_pass_cnt   <= '0;
      r_fail_cnt   <= '0;
      r_skip_cnt   <= '0;
      r_first_fail <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      if (w_start_acc) begin
        r_d_drv      <= 1'b0;
        r_en_drv     <= 1'b0;
        r_exp        <= 1'b0;
        r_exp_valid  <= 1'b0;
        r_idx        <= '0;
        r_num        <= num_checks;
        r_pass_cnt   <= '0;
        r_fail_cnt   <= '0;
        r_skip_cnt   <= '0;
        r_first_fail <= '0;
      end else if (r_state == DRIVE) begin
        r_d_drv  <= w_lfsr[0];
        r_en_drv <= w_lfsr[1];
      end else if (r_state == SAMPLE) begin
        r_exp       <= w_exp_nxt;
        r_exp_valid <= w_exp_valid_nxt;
        r_idx       <= r_idx + ONE_N;
        if (!w_exp_valid_nxt) begin
          r_skip_cnt <= sat_inc(r_skip_cnt);
        end else if (!w_mismatch) begin
          r_pass_cnt <= sat_inc(r_pass_cnt);
        end else begin
          r_fail_cnt  <= sat_inc(r_fail_cnt);
          r_err_pulse <= 1'b1;
          // fail_cnt never decreases within a run, so zero marks the first.
          if (r_fail_cnt == '0) r_first_fail <= r_idx;
        end
      end
    end
  end

  assign d_drv          = r_d_drv;
  assign en_drv         = r_en_drv;
  assign err_pulse      = r_err_pulse;
  assign pass_cnt       = r_pass_cnt;
  assign fail_cnt       = r_fail_cnt;
  assign skip_cnt       = r_skip_cnt;
  assign first_fail_idx = r_first_fail;

endmodule
